// File: rtl/dance_pad_conditioner.sv
// ---------------------------------------------------------------------------
// dance_pad_conditioner
//   Front end for the four raw dance-pad switches. Each pad is brought into
//   the clock domain with a two-flop synchroniser and then debounced by its
//   own four-state machine. The module outputs the clean held levels and
//   one-cycle press/release pulses. Every accepted level change is also
//   recorded as a pending event. An arbiter moves pending events, lowest pad
//   index first, into a small show-ahead FIFO that sits behind a
//   valid/ready port.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset
//   dancePad[3:0]  raw asynchronous pad switches, 1 = stepped on
//   pad_held[3:0]  debounced pad levels
//   press_pulse    one-cycle pulse on a debounced 0->1, per pad
//   release_pulse  one-cycle pulse on a debounced 1->0, per pad
//   evt_valid      the FIFO head holds an event
//   evt_pad[1:0]   pad index of the head event (0 when the FIFO is empty)
//   evt_press      1 = press event, 0 = release event (0 when empty)
//   evt_ready      consumer takes the head event when evt_valid && evt_ready
//   drop_count     saturating count of events lost to pending overwrite
// ---------------------------------------------------------------------------
module dance_pad_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] dancePad,
    output logic [3:0] pad_held,
    output logic [3:0] press_pulse,
    output logic [3:0] release_pulse,
    output logic       evt_valid,
    output logic [1:0] evt_pad,
    output logic       evt_press,
    input  logic       evt_ready,
    output logic [7:0] drop_count
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = PTR_W + 1;
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHG_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHG_LO    = 2'd3
    } db_state_t;

    // Saturating add of up to four drop events to an 8-bit counter.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [2:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {6'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    function automatic logic [2:0] count_ones4(input logic [3:0] v);
        return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
    endfunction

    logic [3:0]       sync_p0;
    logic [3:0]       sync_p1;
    db_state_t        db_state [4];
    logic [CNT_W-1:0] db_cnt   [4];
    logic [3:0]       flip;
    logic [3:0]       flip_lvl;
    logic [3:0]       pend;
    logic [3:0]       pend_kind;
    logic [3:0]       granted;
    logic [3:0]       drop_hit;
    logic             arb_hit;
    logic [1:0]       arb_sel;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [FCNT_W-1:0] fifo_count;
    logic [1:0]       mem_pad   [FIFO_DEPTH];
    logic             mem_press [FIFO_DEPTH];

    // ---- stage p0/p1: two-flop synchroniser ------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= dancePad;
            sync_p1 <= sync_p0;
        end
    end

    // A pad flips when its change state has seen the new level for the
    // full qualification window and the synchronised input still agrees.
    always_comb begin
        flip     = '0;
        flip_lvl = '0;
        for (int i = 0; i < 4; i++) begin
            if (db_cnt[i] == CNT_LAST) begin
                if (db_state[i] == CHG_HI && sync_p1[i]) begin
                    flip[i]     = 1'b1;
                    flip_lvl[i] = 1'b1;
                end
                if (db_state[i] == CHG_LO && !sync_p1[i]) begin
                    flip[i]     = 1'b1;
                    flip_lvl[i] = 1'b0;
                end
            end
        end
    end

    // ---- debounce state machines with registered level and pulses ---------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                db_state[i] <= STABLE_LO;
                db_cnt[i]   <= '0;
            end
            pad_held      <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                press_pulse[i]   <= 1'b0;
                release_pulse[i] <= 1'b0;
                case (db_state[i])
                    STABLE_LO: begin
                        if (sync_p1[i]) begin
                            db_state[i] <= CHG_HI;
                            db_cnt[i]   <= CNT_ONE;
                        end else begin
                            db_cnt[i] <= '0;
                        end
                    end
                    CHG_HI: begin
                        if (!sync_p1[i]) begin
                            db_state[i] <= STABLE_LO;
                            db_cnt[i]   <= '0;
                        end else if (db_cnt[i] == CNT_LAST) begin
                            db_state[i]    <= STABLE_HI;
                            db_cnt[i]      <= '0;
                            pad_held[i]    <= 1'b1;
                            press_pulse[i] <= 1'b1;
                        end else begin
                            db_cnt[i] <= db_cnt[i] + CNT_ONE;
                        end
                    end
                    STABLE_HI: begin
                        if (!sync_p1[i]) begin
                            db_state[i] <= CHG_LO;
                            db_cnt[i]   <= CNT_ONE;
                        end else begin
                            db_cnt[i] <= '0;
                        end
                    end
                    CHG_LO: begin
                        if (sync_p1[i]) begin
                            db_state[i] <= STABLE_HI;
                            db_cnt[i]   <= '0;
                        end else if (db_cnt[i] == CNT_LAST) begin
                            db_state[i]      <= STABLE_LO;
                            db_cnt[i]        <= '0;
                            pad_held[i]      <= 1'b0;
                            release_pulse[i] <= 1'b1;
                        end else begin
                            db_cnt[i] <= db_cnt[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        db_state[i] <= STABLE_LO;
                        db_cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    // Arbiter: lowest-index pending pad wins; the scan runs downwards so the
    // last assignment is the lowest index.
    always_comb begin
        arb_hit = 1'b0;
        arb_sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pend[i]) begin
                arb_hit = 1'b1;
                arb_sel = 2'(i);
            end
        end
        push     = arb_hit && (fifo_count < FIFO_FULL);
        pop      = (fifo_count != '0) && evt_ready;
        granted  = '0;
        drop_hit = '0;
        for (int i = 0; i < 4; i++) begin
            granted[i]  = push && (arb_sel == 2'(i));
            // A pad moved into the FIFO on this edge frees its slot, so a
            // simultaneous flip re-arms it without losing anything.
            drop_hit[i] = flip[i] && pend[i] && !granted[i];
        end
    end

    // ---- pending event flags and drop counter -----------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pend       <= '0;
            pend_kind  <= '0;
            drop_count <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (flip[i]) begin
                    pend[i]      <= 1'b1;
                    pend_kind[i] <= flip_lvl[i];
                end else if (granted[i]) begin
                    pend[i] <= 1'b0;
                end
            end
            drop_count <= sat_add8(drop_count, count_ones4(drop_hit));
        end
    end

    // ---- event FIFO: control -----------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
                2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---- event FIFO: storage -------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pad[wr_ptr]   <= arb_sel;
            mem_press[wr_ptr] <= pend_kind[arb_sel];
        end
    end

    assign evt_valid = (fifo_count != '0);
    assign evt_pad   = evt_valid ? mem_pad[rd_ptr]   : 2'd0;
    assign evt_press = evt_valid ? mem_press[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_dance_pad_conditioner.sv
module tb_dance_pad_conditioner;

    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] dancePad;
    logic [3:0] pad_held;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic       evt_valid;
    logic [1:0] evt_pad;
    logic       evt_press;
    logic       evt_ready;
    logic [7:0] drop_count;

    int errors = 0;
    int checks = 0;

    dance_pad_conditioner #(
        .DEBOUNCE_CYCLES(N),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .dancePad(dancePad),
        .pad_held(pad_held),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .evt_valid(evt_valid),
        .evt_pad(evt_pad),
        .evt_press(evt_press),
        .evt_ready(evt_ready),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Reference model: each pad's debounced level follows the input seen two
    // edges late once that input has disagreed with the level for N edges in
    // a row. Events sit in a pending slot per pad and then in a queue.
    logic [3:0] m_h1, m_h2;
    logic [3:0] m_held, m_press, m_rel, m_pend, m_kind;
    int         m_run [4];
    int         m_drop;
    logic [2:0] m_q [$];

    task automatic model_clear();
        m_h1 = '0; m_h2 = '0; m_held = '0; m_press = '0; m_rel = '0;
        m_pend = '0; m_kind = '0; m_drop = 0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_q.delete();
    endtask

    task automatic model_edge();
        logic [3:0] seen;
        int sel;
        logic do_push, do_pop;
        logic [2:0] item;
        if (reset) begin
            model_clear();
            return;
        end
        seen = m_h2;
        m_h2 = m_h1;
        m_h1 = dancePad;
        sel = -1;
        for (int i = 0; i < 4; i++) if (m_pend[i] && sel < 0) sel = i;
        do_push = (sel >= 0) && (m_q.size() < DEPTH);
        do_pop  = (m_q.size() != 0) && evt_ready;
        item = 3'b0;
        if (do_push) item = {sel[1:0], m_kind[sel]};
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
            m_q.push_back(item);
            m_pend[sel] = 1'b0;
        end
        m_press = '0;
        m_rel   = '0;
        for (int i = 0; i < 4; i++) begin
            if (seen[i] != m_held[i]) m_run[i]++;
            else m_run[i] = 0;
            if (m_run[i] == N) begin
                m_run[i]  = 0;
                m_held[i] = seen[i];
                if (seen[i]) m_press[i] = 1'b1;
                else m_rel[i] = 1'b1;
                if (m_pend[i] && m_drop < 255) m_drop++;
                m_pend[i] = 1'b1;
                m_kind[i] = seen[i];
            end
        end
    endtask

    function automatic logic [23:0] exp_vec();
        logic [2:0] head;
        logic [7:0] d;
        head = (m_q.size() != 0) ? m_q[0] : 3'b0;
        d = m_drop[7:0];
        return {m_held, m_press, m_rel, (m_q.size() != 0), head, d};
    endfunction

    function automatic logic [23:0] got_vec();
        return {pad_held, press_pulse, release_pulse, evt_valid, evt_pad, evt_press, drop_count};
    endfunction

    // Inputs are set at the falling edge; the model advances at the rising
    // edge and outputs are compared at the next falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; dancePad = '0; evt_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; dancePad = 4'hF; evt_ready = 1'b1;
        tick(); tick();
        if (got_vec() !== 24'h0) begin
            errors++; $display("FAIL reset_state got=%h exp=%h", got_vec(), 24'h0);
        end
        checks++;
        dancePad = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_press();
        do_reset();
        for (int k = 0; k < 25; k++) begin
            dancePad  = (k < 12) ? 4'b0001 : 4'b0000;
            evt_ready = (k >= 8);
            tick();
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL press_model k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
            end
            checks++;
            if (k == 4 && {pad_held[0], press_pulse[0]} !== 2'b00) begin
                errors++; $display("FAIL press_early got=%b exp=00", {pad_held[0], press_pulse[0]});
            end
            if (k == 5 && {pad_held[0], press_pulse[0], evt_valid} !== 3'b110) begin
                errors++; $display("FAIL press_edge5 got=%b exp=110", {pad_held[0], press_pulse[0], evt_valid});
            end
            if (k == 6 && {press_pulse[0], evt_valid, evt_pad, evt_press} !== 5'b01001) begin
                errors++; $display("FAIL press_evt6 got=%b exp=01001", {press_pulse[0], evt_valid, evt_pad, evt_press});
            end
            if (k >= 4 && k <= 6) checks++;
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int k = 0; k < 14; k++) begin
            dancePad  = (k < 3) ? 4'b0100 : 4'b0000;
            evt_ready = 1'b0;
            tick();
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL glitch_model k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
            end
            checks++;
            if ({pad_held[2], press_pulse[2], evt_valid, drop_count} !== 11'd0) begin
                errors++; $display("FAIL glitch_quiet k=%0d got=%b exp=0", k, {pad_held[2], press_pulse[2], evt_valid, drop_count});
            end
            checks++;
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int k = 0; k < 12; k++) begin
            dancePad  = 4'b1010;
            evt_ready = 1'b1;
            tick();
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL simul_model k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
            end
            checks++;
            if (k == 6 && {evt_valid, evt_pad, evt_press} !== 4'b1011) begin
                errors++; $display("FAIL simul_first got=%b exp=1011", {evt_valid, evt_pad, evt_press});
            end
            if (k == 7 && {evt_valid, evt_pad, evt_press} !== 4'b1111) begin
                errors++; $display("FAIL simul_second got=%b exp=1111", {evt_valid, evt_pad, evt_press});
            end
            if (k == 8 && evt_valid !== 1'b0) begin
                errors++; $display("FAIL simul_empty got=%b exp=0", evt_valid);
            end
            if (k >= 6 && k <= 8) checks++;
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] seen_q [$];
        logic [2:0] want [5];
        want = '{3'b001, 3'b011, 3'b101, 3'b111, 3'b000};
        do_reset();
        for (int k = 0; k < 34; k++) begin
            dancePad  = (k < 10) ? 4'b1111 : 4'b1110;
            evt_ready = (k >= 20);
            if (evt_ready && evt_valid) seen_q.push_back({evt_pad, evt_press});
            tick();
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL backpr_model k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
            end
            checks++;
        end
        if (seen_q.size() != 5) begin
            errors++; $display("FAIL backpr_count got=%0d exp=5", seen_q.size());
        end
        checks++;
        for (int i = 0; i < 5 && i < seen_q.size(); i++) begin
            if (seen_q[i] !== want[i]) begin
                errors++; $display("FAIL backpr_order i=%0d got=%b exp=%b", i, seen_q[i], want[i]);
            end
            checks++;
        end
        if (drop_count !== 8'd0) begin
            errors++; $display("FAIL backpr_drop got=%0d exp=0", drop_count);
        end
        checks++;
    endtask

    task automatic test_overwrite();
        logic [2:0] seen_q [$];
        do_reset();
        for (int k = 0; k < 56; k++) begin
            dancePad = 4'b0000;
            if (k < 8) dancePad = 4'b1110;
            else dancePad = 4'b0110;
            if (k >= 16 && k < 28) dancePad[0] = 1'b1;
            evt_ready = (k >= 40);
            if (evt_ready && evt_valid) seen_q.push_back({evt_pad, evt_press});
            tick();
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL ovw_model k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
            end
            checks++;
        end
        if (drop_count !== 8'd1) begin
            errors++; $display("FAIL ovw_drop got=%0d exp=1", drop_count);
        end
        checks++;
        if (seen_q.size() != 5 || seen_q[seen_q.size()-1] !== 3'b000) begin
            errors++; $display("FAIL ovw_last n=%0d got=%b exp=000", seen_q.size(),
                               (seen_q.size() != 0) ? seen_q[seen_q.size()-1] : 3'b111);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 24; k++) begin
            dancePad  = (k < 10) ? 4'b0011 : 4'b0010;
            evt_ready = 1'b0;
            reset     = (k == 10);
            tick();
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL rstmid_model k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
            end
            checks++;
            if (k == 9 && evt_valid !== 1'b1) begin
                errors++; $display("FAIL rstmid_queued got=%b exp=1", evt_valid);
            end
            if (k == 10 && {evt_valid, pad_held} !== 5'b0) begin
                errors++; $display("FAIL rstmid_clear got=%b exp=00000", {evt_valid, pad_held});
            end
            if (k == 16 && evt_valid !== 1'b0) begin
                errors++; $display("FAIL rstmid_early got=%b exp=0", evt_valid);
            end
            if (k == 17 && {evt_valid, evt_pad, evt_press} !== 4'b1011) begin
                errors++; $display("FAIL rstmid_fresh got=%b exp=1011", {evt_valid, evt_pad, evt_press});
            end
            if (k == 9 || k == 10 || k == 16 || k == 17) checks++;
        end
        reset = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 0; k < 480; k++) begin
            dancePad  = ((k / 6) % 2 == 0) ? 4'hF : 4'h0;
            evt_ready = 1'b0;
            tick();
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL sat_model k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
            end
            checks++;
        end
        if (drop_count !== 8'd255) begin
            errors++; $display("FAIL sat_final got=%0d exp=255", drop_count);
        end
        checks++;
    endtask

    task automatic test_random();
        logic [3:0] pads;
        pads = '0;
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 5) == 0) pads[i] = ~pads[i];
            dancePad  = pads;
            evt_ready = ($urandom_range(0, 2) != 0);
            reset     = ($urandom_range(0, 299) == 0);
            tick();
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL random_model k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
            end
            checks++;
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; dancePad = '0; evt_ready = 1'b0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_press();
        test_glitch();
        test_simultaneous();
        test_back_to_back();
        test_overwrite();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
